// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a ready/valid handshake and shifts it out
// LSB first between a low start bit and a high stop bit on a registered serial line.
module uart_tx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CLK_CNT_W        = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CLK_CNT_W-1:0] CNT_LAST = CLK_CNT_W'(SYMBOL_EDGE_TIME - 1);

    generate
        if (SYMBOL_EDGE_TIME < 2) begin : g_bad_rate
            $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2 clocks per bit");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CLK_CNT_W-1:0]   r_clk_cnt;
    logic [CLK_CNT_W-1:0]   w_clk_cnt_next;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_next;
    logic [9:0]             r_frame;
    logic [9:0]             w_frame_next;
    logic                   r_ready;
    logic                   w_ready_next;
    logic                   r_serial;
    logic                   w_serial_next;
    logic                   w_bit_end;
    logic [3:0]             w_data_pos;

    assign w_bit_end  = (r_clk_cnt == CNT_LAST);
    // Frame bit 0 is the start bit, so data bit n lives at frame position n+1.
    assign w_data_pos = {1'b0, r_bit_idx} + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_frame   <= '0;
            r_ready   <= 1'b1;
            r_serial  <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_frame   <= w_frame_next;
            r_ready   <= w_ready_next;
            r_serial  <= w_serial_next;
        end
    end

    // The line register takes the level belonging to the current state, so the line
    // trails the state by one clock and the first low appears the edge after accept.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_frame_next   = r_frame;
        w_serial_next  = 1'b1;

        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                if (data_in_valid && r_ready) begin
                    w_frame_next = {1'b1, data_in, 1'b0};
                    w_state_next = START;
                end
            end
            START: begin
                w_serial_next = r_frame[0];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CLK_CNT_W'(1);
                end
            end
            DATA: begin
                w_serial_next = r_frame[w_data_pos];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CLK_CNT_W'(1);
                end
            end
            STOP: begin
                w_serial_next = r_frame[9];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = IDLE;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + CLK_CNT_W'(1);
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase

        w_ready_next = (w_state_next == IDLE);
    end

    assign data_in_ready = r_ready;
    assign serial_out    = r_serial;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a timeline model of the expected line and ready levels, a mid-bit
// sampling receiver, directed frames, random traffic and a default-parameter instance.
module tb_uart_tx;

    localparam int S  = 10;
    localparam int BS = 1085;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic       b_line;

    always #5 clk = ~clk;

    uart_tx #(.CLOCK_FREQ(100), .BAUD_RATE(10)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out)
    );

    uart_tx dut_big (
        .clk(clk), .rst(rst), .data_in(b_data), .data_in_valid(b_valid),
        .data_in_ready(b_ready), .serial_out(b_line)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: after accept edge A the line carries frame bit (c-A-1)/S on edge
    // c for A+1 <= c <= A+10S; ready comes back on edge A+10S.
    longint     m_cyc = 0;
    longint     m_acc = 0;
    bit         m_active = 1'b0;
    bit         m_ready = 1'b1;
    logic [9:0] m_frame = 10'h3FF;
    int         sent_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_ready  <= 1'b1;
        end else if (m_ready && data_in_valid) begin
            m_active <= 1'b1;
            m_acc    <= m_cyc + 1;
            m_frame  <= {1'b1, data_in, 1'b0};
            m_ready  <= 1'b0;
            sent_q.push_back(int'(data_in));
        end else begin
            m_ready <= !m_active || (m_cyc + 1 >= m_acc + 10 * S);
        end
        m_cyc <= m_cyc + 1;
    end

    int         rx_t = -1;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_sh = 8'h00;
    int         rx_q[$];
    int         rx_rd = 0;
    int         sent_rd = 0;

    // One negedge: compare against the model, then advance the sampling receiver.
    task automatic step();
        logic   exp_line;
        logic   exp_ready;
        longint k;
        @(negedge clk);
        exp_line  = 1'b1;
        exp_ready = 1'b1;
        if (!rst) begin
            exp_ready = m_ready;
            if (m_active && m_cyc >= m_acc + 1 && m_cyc <= m_acc + 10 * S) begin
                k = (m_cyc - m_acc - 1) / S;
                exp_line = m_frame[int'(k)];
            end
        end
        chk("line", {31'd0, serial_out}, {31'd0, exp_line});
        chk("ready", {31'd0, data_in_ready}, {31'd0, exp_ready});
        if (rst) begin
            rx_t    = -1;
            rx_prev = 1'b1;
        end else begin
            if (rx_t < 0) begin
                if (rx_prev === 1'b1 && serial_out === 1'b0) rx_t = 0;
            end else begin
                rx_t++;
            end
            if (rx_t >= 0 && (rx_t % S) == S / 2) begin
                k = rx_t / S;
                if (k == 0) begin
                    if (serial_out !== 1'b0) rx_t = -1;
                end else if (k <= 8) begin
                    rx_sh[int'(k) - 1] = serial_out;
                end else begin
                    rx_q.push_back(serial_out === 1'b1 ? int'(rx_sh) : -1);
                    rx_t = -1;
                end
            end
            rx_prev = serial_out;
        end
    endtask

    task automatic rx_expect(input string name, input int exp);
        int b;
        for (int i = 0; i < 400 && rx_q.size() <= rx_rd; i++) step();
        if (rx_q.size() > rx_rd) begin
            b = rx_q[rx_rd];
            rx_rd++;
        end else begin
            b = -2;
        end
        chk(name, b, exp);
    endtask

    task automatic sent_expect(input string name, input int exp);
        int b;
        if (sent_q.size() > sent_rd) begin
            b = sent_q[sent_rd];
            sent_rd++;
        end else begin
            b = -2;
        end
        chk(name, b, exp);
    endtask

    initial begin
        logic [9:0] a5_seq;
        int phase, low1, high, fall, rise, rdy;

        repeat (3) step();
        rst = 1'b0;
        repeat (50) step();
        chk("idle_line", {31'd0, serial_out}, 32'd1);
        chk("idle_ready", {31'd0, data_in_ready}, 32'd1);

        // 0xA5 with a single-cycle valid pulse
        a5_seq = 10'b11_0100_1010;
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        chk("ready_drop_on_accept", {31'd0, data_in_ready}, 32'd0);
        chk("line_high_on_accept", {31'd0, serial_out}, 32'd1);
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("a5_bit", {31'd0, serial_out}, {31'd0, a5_seq[(i - 1) / 10]});
            if (i == 99) chk("a5_ready_at_99", {31'd0, data_in_ready}, 32'd0);
            if (i == 100) chk("a5_ready_at_100", {31'd0, data_in_ready}, 32'd1);
        end
        rx_expect("rx_a5", 32'hA5);
        sent_expect("model_a5", 32'hA5);

        // Back-to-back 0x00 then 0xFF with valid held
        repeat (5) step();
        data_in = 8'h00;
        data_in_valid = 1'b1;
        step();
        data_in = 8'hFF;
        phase = 0; low1 = 0; high = 0;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (i == 150) data_in_valid = 1'b0;
            case (phase)
                0: if (serial_out === 1'b0) begin phase = 1; low1 = 1; end
                1: if (serial_out === 1'b0) low1++; else begin phase = 2; high = 1; end
                2: if (serial_out === 1'b1) high++; else phase = 3;
                default: ;
            endcase
        end
        chk("b2b_low_run_00", low1, 90);
        chk("b2b_high_stop_plus_gap", high, 11);
        rx_expect("rx_00", 32'h00);
        rx_expect("rx_ff", 32'hFF);
        sent_expect("model_00", 32'h00);
        sent_expect("model_ff", 32'hFF);

        // 0x3C accepted, then 0x99 offered while busy
        repeat (5) step();
        data_in = 8'h3C;
        data_in_valid = 1'b1;
        step();
        data_in = 8'h99;
        for (int i = 1; i <= 120; i++) begin
            step();
            if (i == 110) data_in_valid = 1'b0;
        end
        rx_expect("rx_3c", 32'h3C);
        rx_expect("rx_99", 32'h99);
        sent_expect("model_3c", 32'h3C);
        sent_expect("model_99", 32'h99);

        // Asynchronous reset during data bit 3 of 0x55
        repeat (110) step();
        data_in = 8'h55;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        repeat (44) step();
        chk("bit3_of_55", {31'd0, serial_out}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_line", {31'd0, serial_out}, 32'd1);
        chk("async_rst_ready", {31'd0, data_in_ready}, 32'd1);
        repeat (3) step();
        rst = 1'b0;
        chk("no_byte_from_aborted_frame", rx_q.size(), rx_rd);
        repeat (3) step();
        data_in = 8'h81;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        rx_expect("rx_81", 32'h81);
        sent_expect("model_55", 32'h55);
        sent_expect("model_81", 32'h81);
        repeat (20) step();

        // Random traffic against the model
        rx_rd = rx_q.size();
        sent_rd = sent_q.size();
        for (int i = 0; i < 1500; i++) begin
            data_in = 8'($urandom);
            data_in_valid = ($urandom_range(0, 3) == 0);
            step();
        end
        data_in_valid = 1'b0;
        repeat (250) step();
        chk("rand_byte_count", rx_q.size() - rx_rd, sent_q.size() - sent_rd);
        while (sent_rd < sent_q.size() && rx_rd < rx_q.size()) begin
            chk("rand_byte", rx_q[rx_rd], sent_q[sent_rd]);
            rx_rd++;
            sent_rd++;
        end

        // Default parameters: 1085 clocks per bit
        b_data = 8'h01;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        fall = -1; rise = -1; rdy = -1;
        for (int i = 1; i <= 11000 && rdy < 0; i++) begin
            step();
            if (fall < 0 && b_line === 1'b0) fall = i;
            else if (fall >= 0 && rise < 0 && b_line === 1'b1) rise = i;
            if (b_ready === 1'b1) rdy = i;
        end
        chk("big_first_fall", fall, 1);
        chk("big_bit_period", rise - fall, BS);
        chk("big_frame_len", rdy, 10 * BS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
